// File: rtl/oldland_debug_bridge.sv
// Host-side debug mailbox initiator: 9-byte host frame in, mailbox writes, req/ack handshake, 4-byte result out.
// Optional macro DEBUG_BRIDGE_TIMEOUT_EN bounds every ack wait and returns 32'hFFFFFFFF on expiry.
module oldland_debug_bridge #(
  parameter int unsigned timeout_cycles = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [1:0]  o_dbg_addr,
  output logic [31:0] o_dbg_din,
  output logic        o_dbg_wr_en,
  input  logic [31:0] i_dbg_dout,
  output logic        o_dbg_req,
  input  logic        i_dbg_ack,
  output logic        o_busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_IDLE, S_WR_CMD, S_WR_ADDR, S_WR_DATA,
    S_REQ, S_READ, S_LATCH, S_RELEASE, S_TX
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [7:0]          r_cmd, w_cmd_nxt;
  logic [WORD_W-1:0]   r_addr, w_addr_nxt;
  logic [WORD_W-1:0]   r_data, w_data_nxt;
  logic [WORD_W-1:0]   r_result, w_result_nxt;
  logic                r_err, w_err_nxt;
  logic                w_timeout;
  logic                w_rx_fire, w_tx_fire;

  logic                w_rx_ready, w_tx_valid, w_dbg_wr_en, w_dbg_req, w_busy;
  logic [7:0]          w_tx_data;
  logic [1:0]          w_dbg_addr;
  logic [WORD_W-1:0]   w_dbg_din;

  assign w_rx_fire = i_rx_valid && o_rx_ready;
  assign w_tx_fire = o_tx_valid && i_tx_ready;

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMR_W = 32;
  logic [TMR_W-1:0] r_timer;

  assign w_timeout = (r_timer == TMR_W'(timeout_cycles - 1));

  // Wait-state cycle counter, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if (r_state == S_WAIT_IDLE || r_state == S_REQ || r_state == S_RELEASE) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^WORD_W'(timeout_cycles);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_cmd    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cmd    <= w_cmd_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next state, frame capture and result latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cmd_nxt    = r_cmd;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          case (r_cnt)
            4'd0: begin w_cmd_nxt = i_rx_data; w_err_nxt = 1'b0; end
            4'd1: w_addr_nxt[7:0]   = i_rx_data;
            4'd2: w_addr_nxt[15:8]  = i_rx_data;
            4'd3: w_addr_nxt[23:16] = i_rx_data;
            4'd4: w_addr_nxt[31:24] = i_rx_data;
            4'd5: w_data_nxt[7:0]   = i_rx_data;
            4'd6: w_data_nxt[15:8]  = i_rx_data;
            4'd7: w_data_nxt[23:16] = i_rx_data;
            4'd8: w_data_nxt[31:24] = i_rx_data;
            default: ;
          endcase
          if (r_cnt == CNT_W'(8)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_WAIT_IDLE: begin
        // A stale ack from the previous transaction must clear before this one starts.
        if (!i_dbg_ack) begin
          w_state_nxt = S_WR_CMD;
        end else if (w_timeout) begin
          w_result_nxt = '1;
          w_err_nxt    = 1'b1;
          w_state_nxt  = S_TX;
        end
      end
      S_WR_CMD:  w_state_nxt = S_WR_ADDR;
      S_WR_ADDR: w_state_nxt = S_WR_DATA;
      S_WR_DATA: w_state_nxt = S_REQ;
      S_REQ: begin
        if (i_dbg_ack) begin
          w_state_nxt = S_READ;
        end else if (w_timeout) begin
          w_result_nxt = '1;
          w_err_nxt    = 1'b1;
          w_state_nxt  = S_RELEASE;
        end
      end
      S_READ: w_state_nxt = S_LATCH;
      S_LATCH: begin
        w_result_nxt = i_dbg_dout;
        w_state_nxt  = S_RELEASE;
      end
      S_RELEASE: begin
        if (!i_dbg_ack) begin
          w_state_nxt = S_TX;
        end else if (w_timeout) begin
          w_result_nxt = '1;
          w_err_nxt    = 1'b1;
          w_state_nxt  = S_TX;
        end
      end
      S_TX: begin
        if (w_tx_fire) begin
          if (w_cnt_nxt == CNT_W'(3)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state register.
  always_comb begin
    w_rx_ready  = 1'b0;
    w_tx_valid  = 1'b0;
    w_tx_data   = '0;
    w_dbg_addr  = '0;
    w_dbg_din   = '0;
    w_dbg_wr_en = 1'b0;
    w_dbg_req   = 1'b0;
    w_busy      = (w_state_nxt != S_IDLE) || (w_cnt_nxt != '0) || w_err_nxt;
    case (w_state_nxt)
      S_IDLE:    w_rx_ready = 1'b1;
      S_WR_CMD:  begin w_dbg_addr = 2'd0; w_dbg_din = {24'b0, w_cmd_nxt}; w_dbg_wr_en = 1'b1; end
      S_WR_ADDR: begin w_dbg_addr = 2'd1; w_dbg_din = w_addr_nxt;         w_dbg_wr_en = 1'b1; end
      S_WR_DATA: begin w_dbg_addr = 2'd2; w_dbg_din = w_data_nxt;         w_dbg_wr_en = 1'b1; end
      S_REQ, S_READ: begin w_dbg_addr = 2'd3; w_dbg_req = 1'b1; end
      S_LATCH:   w_dbg_addr = 2'd3;
      S_TX: begin
        w_tx_valid = 1'b1;
        w_tx_data  = 8'(w_result_nxt >> {w_cnt_nxt[1:0], 3'b000});
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rx_ready  <= 1'b0;
      o_tx_valid  <= 1'b0;
      o_tx_data   <= '0;
      o_dbg_addr  <= '0;
      o_dbg_din   <= '0;
      o_dbg_wr_en <= 1'b0;
      o_dbg_req   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_rx_ready  <= w_rx_ready;
      o_tx_valid  <= w_tx_valid;
      o_tx_data   <= w_tx_data;
      o_dbg_addr  <= w_dbg_addr;
      o_dbg_din   <= w_dbg_din;
      o_dbg_wr_en <= w_dbg_wr_en;
      o_dbg_req   <= w_dbg_req;
      o_busy      <= w_busy;
    end
  end

endmodule

// File: tb/tb_oldland_debug_bridge.sv
// Testbench for oldland_debug_bridge: random frames against a mailbox/CPU responder and a frame-level reference.
// Define DEBUG_BRIDGE_TIMEOUT_EN for both files to also exercise the ack timeout (timeout_cycles = 16).
module tb_oldland_debug_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  dbg_addr;
  logic [31:0] dbg_din;
  logic        dbg_wr_en;
  logic [31:0] dbg_dout = 32'h0;
  logic        dbg_req;
  logic        dbg_ack;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic        r_ack = 1'b0;
  logic        rsp_st = 1'b0;
  int          rsp_cnt = 0;
  int          cfg_dly = 0;
  bit          rsp_en = 1'b1;
  bit          force_ack = 1'b0;
  logic [31:0] rsp_word = 32'h0;
  int          both_viol = 0;

  always #5 clk = ~clk;

  assign dbg_ack = r_ack | force_ack;

  oldland_debug_bridge #(.timeout_cycles(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_dbg_addr(dbg_addr), .o_dbg_din(dbg_din), .o_dbg_wr_en(dbg_wr_en),
    .i_dbg_dout(dbg_dout), .o_dbg_req(dbg_req), .i_dbg_ack(dbg_ack),
    .o_busy(busy)
  );

  // Mailbox RAM (registered read) plus CPU side: posts rsp_word to word 3, then acks after cfg_dly cycles.
  always @(posedge clk) begin
    if (dbg_wr_en) mem[dbg_addr] <= dbg_din;
    dbg_dout <= mem[dbg_addr];
    if (!rsp_st) begin
      if (!dbg_req) rsp_cnt <= 0;
      else if (rsp_en) begin
        if (rsp_cnt >= cfg_dly) begin
          mem[3] <= rsp_word;
          r_ack  <= 1'b1;
          rsp_st <= 1'b1;
        end else rsp_cnt <= rsp_cnt + 1;
      end
    end else if (!dbg_req) begin
      r_ack   <= 1'b0;
      rsp_st  <= 1'b0;
      rsp_cnt <= 0;
    end
  end

  always @(negedge clk) if (dbg_wr_en && dbg_req) both_viol <= both_viol + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({rx_ready, tx_valid, tx_data, dbg_addr, dbg_wr_en, dbg_req, busy}), 32'h0);
    chk({tag, "_din"}, dbg_din, 32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_data = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 100) begin @(negedge clk); t++; end
    chk("rx_accept", 32'(rx_ready), 32'h1);
    @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                          input bit stall, input int hold, input bit exp_to);
    logic [7:0]  fb [9];
    logic [31:0] exp_din [3];
    logic [31:0] exp_res;
    logic [7:0]  b0;
    int          n, t, req_n, req_len;
    int          wn[$];
    logic [1:0]  wa[$];
    logic [31:0] wd[$];
    fb = '{cmd, addr[7:0], addr[15:8], addr[23:16], addr[31:24],
           data[7:0], data[15:8], data[23:16], data[31:24]};
    exp_din = '{{24'h0, cmd}, addr, data};
    rsp_word = $urandom;
    cfg_dly  = $urandom_range(0, 4);
    exp_res  = exp_to ? 32'hFFFF_FFFF : rsp_word;
    force_ack = (hold > 0);
    for (int i = 0; i < 9; i++) begin
      send_byte(fb[i]);
      if (i == 0) chk("busy_after_byte0", 32'(busy), 32'h1);
    end
    rx_valid = 1'b0;
    if (hold > 0) begin
      t = 0;
      for (int k = 0; k < hold; k++) begin
        if (dbg_wr_en || dbg_req) t++;
        @(negedge clk);
      end
      chk("stale_ack_blocks", 32'(t), 32'h0);
      force_ack = 1'b0;
    end
    n = 0;
    req_n = -1;
    while (n < 200) begin
      if (dbg_wr_en) begin wn.push_back(n); wa.push_back(dbg_addr); wd.push_back(dbg_din); end
      if (dbg_req) begin req_n = n; break; end
      @(negedge clk);
      n++;
    end
    chk("req_latency", 32'(req_n), 32'd4);
    chk("wr_count", 32'(wn.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wn.size()) begin
        chk($sformatf("wr%0d_cycle", i), 32'(wn[i]), 32'(i + 1));
        chk($sformatf("wr%0d_addr", i), 32'(wa[i]), 32'(i));
        chk($sformatf("wr%0d_din", i), wd[i], exp_din[i]);
      end
    end
    if (exp_to) begin
      req_len = 0;
      while (dbg_req && req_len < 100) begin req_len++; @(negedge clk); end
      chk("req_timeout_len", 32'(req_len), 32'd16);
    end
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!tx_valid && t < 300) begin @(negedge clk); t++; end
      chk($sformatf("tx%0d_valid", i), 32'(tx_valid), 32'h1);
      if (stall) begin
        b0 = tx_data;
        t = 0;
        for (int k = 0; k < 10; k++) begin
          if (tx_data !== b0 || rx_ready || !tx_valid) t++;
          @(negedge clk);
        end
        chk($sformatf("tx%0d_stall_stable", i), 32'(t), 32'h0);
      end
      chk($sformatf("tx%0d_byte", i), 32'(tx_data), 32'(exp_res[8*i +: 8]));
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
    chk("busy_end", 32'(busy), 32'(exp_to));
    chk("tx_idle", 32'({tx_valid, tx_data}), 32'h0);
  endtask

  initial begin
    int t;
    rx_data = 8'h0; rx_valid = 1'b0; tx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_frame(8'h03, 32'h0000_0005, 32'h0, 1'b0, 0, 1'b0);
    do_frame(8'h08, 32'h2000_0000, 32'h1234_5678, 1'b0, 0, 1'b0);
    do_frame(8'($urandom), $urandom, $urandom, 1'b0, 7, 1'b0);
    do_frame(8'($urandom), $urandom, $urandom, 1'b1, 0, 1'b0);

    // Reset in the middle of a frame
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("rst_midframe");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_frame(8'($urandom), $urandom, $urandom, 1'b0, 0, 1'b0);

    // Reset while req is high
    for (int i = 0; i < 9; i++) send_byte(8'($urandom));
    rx_valid = 1'b0;
    t = 0;
    while (!dbg_req && t < 50) begin @(negedge clk); t++; end
    chk("req_before_reset", 32'(dbg_req), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("rst_req");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int f = 0; f < 5; f++)
      do_frame(8'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b0);

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    rsp_en = 1'b0;
    do_frame(8'($urandom), $urandom, $urandom, 1'b0, 0, 1'b1);
    rsp_en = 1'b1;
    do_frame(8'($urandom), $urandom, $urandom, 1'b0, 0, 1'b0);
`endif

    chk("no_wr_during_req", 32'(both_viol), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/oldland_debug_bridge.md
Name: oldland_debug_bridge

Overview:
- Host-side initiator for the CPU debug mailbox, in the debug clock domain.
- Accepts a byte-serial command frame from a host byte transport (UART/JTAG shim) and writes the CPU debug controller's 4-word mailbox: 0 = cmd, 1 = addr, 2 = data, 3 = result.
- Runs the req/ack four-phase handshake, reads the result word and streams it back to the host as bytes.

Parameters:
- timeout_cycles, 1000000: cycles to wait for each ack edge before aborting; used only with DEBUG_BRIDGE_TIMEOUT_EN.

Ports:
- clk  in  1  debug clock; same clock as the mailbox debug-side port.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  host byte in.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts a byte this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid; holds until accepted.
- tx_ready  in  1  host accepts tx_data.
- dbg_addr  out  2  mailbox word select.
- dbg_din  out  32  mailbox write data.
- dbg_wr_en  out  1  mailbox write strobe.
- dbg_dout  in  32  mailbox read data; valid 1 cycle after dbg_addr (registered RAM).
- dbg_req  out  1  request to the CPU-side controller (it synchronizes it).
- dbg_ack  in  1  acknowledge, already synchronized into clk.
- busy  out  1  high from first frame byte accepted until last response byte accepted.

Behaviour:
- Reset (async, rst_n low): state IDLE, byte counter 0. All outputs 0: rx_ready, tx_valid, tx_data, dbg_addr, dbg_din, dbg_wr_en, dbg_req, busy. Partial frame, handshake or response in progress is discarded.
- Frame: 9 bytes = cmd, addr[7:0], addr[15:8], addr[23:16], addr[31:24], data[7:0] .. data[31:24] (little-endian).
- Response: always 4 bytes, result[7:0] first. The host ignores it for commands that return no value.
- A byte transfers on rx_valid && rx_ready; a response byte transfers on tx_valid && tx_ready.
- States:
  - IDLE / RX: rx_ready = 1. Count bytes 0..8 into cmd/addr/data registers. After byte 8 go to WAIT_IDLE. busy rises on byte 0.
  - WAIT_IDLE: rx_ready = 0. Stay until dbg_ack == 0, so a stale ack from a previous transaction cannot be taken as this one's.
  - WR_CMD: dbg_addr = 0, dbg_din = {24'b0, cmd}, dbg_wr_en = 1. Lasts 1 cycle.
  - WR_ADDR: dbg_addr = 1, dbg_din = addr, dbg_wr_en = 1. Lasts 1 cycle.
  - WR_DATA: dbg_addr = 2, dbg_din = data, dbg_wr_en = 1. Lasts 1 cycle.
  - REQ: dbg_req = 1 (registered, first high the cycle after the WR_DATA write), dbg_addr = 3. Stay until dbg_ack == 1.
  - READ: dbg_req stays 1, dbg_addr = 3. Wait 1 cycle for registered read data.
  - LATCH: capture dbg_dout into result; dbg_req <= 0.
  - RELEASE: dbg_req = 0. Stay until dbg_ack == 0.
  - TX: present result bytes 0..3 in turn. Each is held until accepted. After byte 3 accepted: busy = 0, go to IDLE.
- Ordering: all three mailbox writes strictly precede req rising. dbg_wr_en is never high while dbg_req is high.
- Latency, ack already low, zero wait states: req high 4 cycles after the last rx byte is accepted. Result is latched 2 cycles after ack is first seen high.
- rx_valid is ignored outside IDLE/RX (rx_ready = 0). The host must not pipeline frames.
- tx_valid is 0 outside TX. tx_data is 0 when tx_valid is 0.
- Command values are not decoded. Unknown commands pass through and still produce 4 response bytes.

Optional Feature:
- DEBUG_BRIDGE_TIMEOUT_EN defined: a cycle counter runs in WAIT_IDLE, REQ and RELEASE, cleared on each state entry.
  - Reaching timeout_cycles - 1 in REQ: drop dbg_req, set result = 32'hFFFFFFFF, go to RELEASE.
  - Reaching it in WAIT_IDLE or RELEASE: skip to TX, returning 32'hFFFFFFFF.
  - A sticky error flag is ORed into busy until the next frame's byte 0.
- Undefined: no counter; the bridge waits on ack indefinitely.

Test Plan:
- Frame cmd 0x03, addr 0x00000005, data 0: mailbox writes words 0/1/2 = 3/5/0 on consecutive cycles, then req. Responder acks with word 3 = 0xDEADBEEF -> tx bytes EF BE AD DE, busy falls after the 4th byte.
- Frame cmd 0x08, addr 0x20000000, data 0x12345678 -> dbg_din sequence 0x8, 0x20000000, 0x12345678. Response bytes are whatever word 3 holds (e.g. 00 00 00 00).
- dbg_ack held high when byte 8 arrives -> no write and no req until ack is low. Then the normal sequence.
- tx_ready low for 10 cycles on each byte -> tx_data stable and no byte skipped. rx_ready stays 0 throughout.
- rst_n pulsed low after 4 rx bytes, and again while req is high -> outputs 0 immediately. A following full frame completes normally.
- With DEBUG_BRIDGE_TIMEOUT_EN, timeout_cycles = 16, ack never rises -> req drops after 16 cycles in REQ. Response FF FF FF FF.
